// File: rtl/sd2snes_mem_pkg.sv
// sd2snes_mem_pkg: shared state, slot record and timing default for the ROM port (MCU states exist only with ROM_PORT_MCU_EN)
package sd2snes_mem_pkg;
  localparam int ROM_CYCLES_DEFAULT = 5;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNES_RD = 3'd1,
    SNES_WR = 3'd2,
`ifdef ROM_PORT_MCU_EN
    MCU_RD  = 3'd3,
    MCU_WR  = 3'd4,
`endif
    TURN    = 3'd5
  } state_e;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [23:0] addr;
    logic [7:0]  data;
  } slot_t;
endpackage

// File: rtl/rom_req_slot.sv
// rom_req_slot: one-deep request latch, latest request wins, same-cycle request visible on cur_o
module rom_req_slot
  import sd2snes_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set_i,
  input  logic  clr_i,
  input  slot_t req_i,
  output slot_t cur_o
);
  slot_t slot_q;
  assign cur_o = set_i ? req_i : slot_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) slot_q <= '0;
    else if (clr_i) slot_q <= '0;
    else if (set_i) slot_q <= req_i;
endmodule

// File: rtl/rom_port_ctrl.sv
// rom_port_ctrl: SNES/MCU arbiter driving fixed-length SRAM accesses; MCU port present only with ROM_PORT_MCU_EN
module rom_port_ctrl
  import sd2snes_mem_pkg::*;
#(
  parameter int ROM_CYCLES = ROM_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        snes_rd_start,
  input  logic        snes_wr_end,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DATA_IN,
  output logic [7:0]  snes_rddata,
  output logic        snes_rd_valid,
  input  logic        mcu_rrq,
  input  logic        mcu_wrq,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wrdata,
  output logic        mcu_rdy,
  output logic [7:0]  mcu_rddata,
  output logic [22:0] ROM_A,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        ROM_BHE_N,
  output logic        ROM_BLE_N,
  output logic [15:0] ROM_DQ_OUT,
  output logic        ROM_DQ_OE,
  input  logic [15:0] ROM_DQ_IN
);
  localparam int CW = $clog2(ROM_CYCLES + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  slot_t snes_cur, snes_req, acc_q, acc_d;
  logic snes_rq, snes_wq, snes_gnt, arb, last, in_acc_d;
  logic [7:0] lane;
  assign snes_rq  = snes_rd_start & ROM_HIT;
  assign snes_wq  = snes_wr_end & ROM_HIT & IS_WRITABLE;
  assign snes_req = '{valid: 1'b1, write: snes_wq, addr: ROM_ADDR, data: SNES_DATA_IN};
  assign arb      = state_q == IDLE || state_q == TURN;
  assign last     = cnt_q == CW'(ROM_CYCLES);
  assign snes_gnt = arb & snes_cur.valid;
  assign lane     = acc_q.addr[0] ? ROM_DQ_IN[15:8] : ROM_DQ_IN[7:0];
  assign in_acc_d = !(state_d inside {IDLE, TURN});
  rom_req_slot u_snes_slot (
    .clk(CLK), .rst(RST), .set_i(snes_rq | snes_wq), .clr_i(snes_gnt),
    .req_i(snes_req), .cur_o(snes_cur)
  );
`ifdef ROM_PORT_MCU_EN
  slot_t mcu_cur, mcu_req;
  logic mcu_set, mcu_gnt, prev_mcu_q;
  assign mcu_set = mcu_rdy & (mcu_rrq | mcu_wrq);
  assign mcu_req = '{valid: 1'b1, write: mcu_wrq, addr: mcu_addr, data: mcu_wrdata};
  assign mcu_gnt = arb & ~snes_cur.valid & mcu_cur.valid;
  rom_req_slot u_mcu_slot (
    .clk(CLK), .rst(RST), .set_i(mcu_set), .clr_i(mcu_gnt),
    .req_i(mcu_req), .cur_o(mcu_cur)
  );
  // ready returns once the turnaround after the MCU's own access has finished
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      mcu_rdy    <= 1'b1;
      mcu_rddata <= '0;
      prev_mcu_q <= 1'b0;
    end else begin
      prev_mcu_q <= state_q inside {MCU_RD, MCU_WR};
      if (mcu_set) mcu_rdy <= 1'b0;
      else if (state_q == TURN && prev_mcu_q) mcu_rdy <= 1'b1;
      if (state_q == MCU_RD && last) mcu_rddata <= lane;
    end
`else
  logic unused_mcu;
  assign unused_mcu = ^{mcu_rrq, mcu_wrq, mcu_addr, mcu_wrdata};
  assign mcu_rdy    = 1'b1;
  assign mcu_rddata = '0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (snes_gnt) begin
      state_d = snes_cur.write ? SNES_WR : SNES_RD;
      cnt_d   = CW'(1);
      acc_d   = snes_cur;
`ifdef ROM_PORT_MCU_EN
    end else if (mcu_gnt) begin
      state_d = mcu_cur.write ? MCU_WR : MCU_RD;
      cnt_d   = CW'(1);
      acc_d   = mcu_cur;
`endif
    end else if (arb) begin
      state_d = IDLE;
    end else if (last) begin
      state_d = TURN;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  // pins are registered from next-state so the bus never sees a combinational input path
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      ROM_A         <= '0;
      ROM_DQ_OUT    <= '0;
      ROM_CE_N      <= 1'b1;
      ROM_OE_N      <= 1'b1;
      ROM_WE_N      <= 1'b1;
      ROM_BHE_N     <= 1'b1;
      ROM_BLE_N     <= 1'b1;
      ROM_DQ_OE     <= 1'b0;
      snes_rddata   <= '0;
      snes_rd_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      ROM_A         <= acc_d.addr[23:1];
      ROM_DQ_OUT    <= {2{acc_d.data}};
      ROM_CE_N      <= ~in_acc_d;
      ROM_OE_N      <= ~(in_acc_d & ~acc_d.write);
      ROM_WE_N      <= ~(in_acc_d & acc_d.write & (cnt_d >= CW'(2)) & (cnt_d < CW'(ROM_CYCLES)));
      ROM_BHE_N     <= ~(in_acc_d & acc_d.addr[0]);
      ROM_BLE_N     <= ~(in_acc_d & ~acc_d.addr[0]);
      ROM_DQ_OE     <= in_acc_d & acc_d.write;
      snes_rd_valid <= state_q == SNES_RD && last;
      if (state_q == SNES_RD && last) snes_rddata <= lane;
    end
endmodule

// File: tb/tb_rom_port_ctrl.sv
// tb_rom_port_ctrl: directed checks of the ROM port; MCU scenarios run only when built with ROM_PORT_MCU_EN
module tb_rom_port_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        snes_rd_start = 1'b0, snes_wr_end = 1'b0;
  logic [23:0] ROM_ADDR = '0;
  logic        ROM_HIT = 1'b0, IS_WRITABLE = 1'b0;
  logic [7:0]  SNES_DATA_IN = '0;
  logic [7:0]  snes_rddata;
  logic        snes_rd_valid;
  logic        mcu_rrq = 1'b0, mcu_wrq = 1'b0;
  logic [23:0] mcu_addr = '0;
  logic [7:0]  mcu_wrdata = '0;
  logic        mcu_rdy;
  logic [7:0]  mcu_rddata;
  logic [22:0] ROM_A;
  logic        ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N;
  logic [15:0] ROM_DQ_OUT;
  logic        ROM_DQ_OE;
  logic [15:0] ROM_DQ_IN = '0;
  int vec = 0;
  int err = 0;

  rom_port_ctrl dut (
    .CLK(CLK), .RST(RST), .snes_rd_start(snes_rd_start), .snes_wr_end(snes_wr_end),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE), .SNES_DATA_IN(SNES_DATA_IN),
    .snes_rddata(snes_rddata), .snes_rd_valid(snes_rd_valid),
    .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr), .mcu_wrdata(mcu_wrdata),
    .mcu_rdy(mcu_rdy), .mcu_rddata(mcu_rddata),
    .ROM_A(ROM_A), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N), .ROM_WE_N(ROM_WE_N),
    .ROM_BHE_N(ROM_BHE_N), .ROM_BLE_N(ROM_BLE_N), .ROM_DQ_OUT(ROM_DQ_OUT),
    .ROM_DQ_OE(ROM_DQ_OE), .ROM_DQ_IN(ROM_DQ_IN)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    @(negedge CLK);
    vec++; if ({ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N} !== 5'b11111) begin err++; $display("FAIL reset_strobes got %b exp 11111", {ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N}); end
    vec++; if ({ROM_DQ_OE, ROM_A, ROM_DQ_OUT} !== 40'd0) begin err++; $display("FAIL reset_bus got oe=%b a=%h dq=%h exp 0", ROM_DQ_OE, ROM_A, ROM_DQ_OUT); end
    vec++; if ({snes_rd_valid, snes_rddata} !== 9'd0) begin err++; $display("FAIL reset_snes got v=%b d=%h exp 0", snes_rd_valid, snes_rddata); end
    vec++; if ({mcu_rdy, mcu_rddata} !== 9'h100) begin err++; $display("FAIL reset_mcu got rdy=%b d=%h exp rdy=1 d=00", mcu_rdy, mcu_rddata); end
    RST = 1'b0;
    @(negedge CLK);
    vec++; if (ROM_CE_N !== 1'b1 || mcu_rdy !== 1'b1) begin err++; $display("FAIL post_reset_idle got ce=%b rdy=%b exp 1 1", ROM_CE_N, mcu_rdy); end
  endtask

  task automatic test_snes_read();
    logic act;
    ROM_ADDR = 24'h000001; ROM_HIT = 1'b1; ROM_DQ_IN = 16'hA55A; snes_rd_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      snes_rd_start = 1'b0;
      act = c <= 5;
      vec++; if ({ROM_CE_N, ROM_OE_N, ROM_BHE_N, ROM_BLE_N, ROM_WE_N} !== {~act, ~act, ~act, 1'b1, 1'b1}) begin err++; $display("FAIL rd_strobes c%0d got %b exp %b", c, {ROM_CE_N, ROM_OE_N, ROM_BHE_N, ROM_BLE_N, ROM_WE_N}, {~act, ~act, ~act, 1'b1, 1'b1}); end
      vec++; if (snes_rd_valid !== (c == 6)) begin err++; $display("FAIL rd_valid c%0d got %b exp %b", c, snes_rd_valid, c == 6); end
      if (act) begin
        vec++; if (ROM_A !== 23'h0 || ROM_DQ_OE !== 1'b0) begin err++; $display("FAIL rd_addr c%0d got a=%h oe=%b exp 0 0", c, ROM_A, ROM_DQ_OE); end
      end
      if (c == 6) begin
        vec++; if (snes_rddata !== 8'hA5) begin err++; $display("FAIL rd_data got %h exp a5", snes_rddata); end
      end
    end
  endtask

  task automatic test_qualify();
    logic act, we;
    int  we_cnt = 0;
    ROM_ADDR = 24'h0000FF; ROM_HIT = 1'b0; snes_rd_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      snes_rd_start = 1'b0;
      vec++; if (ROM_CE_N !== 1'b1 || snes_rd_valid !== 1'b0) begin err++; $display("FAIL unhit_rd c%0d got ce=%b v=%b exp 1 0", c, ROM_CE_N, snes_rd_valid); end
    end
    ROM_ADDR = 24'hE00010; ROM_HIT = 1'b1; IS_WRITABLE = 1'b0; SNES_DATA_IN = 8'h3C; snes_wr_end = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      snes_wr_end = 1'b0;
      vec++; if ({ROM_CE_N, ROM_WE_N, ROM_DQ_OE} !== 3'b110) begin err++; $display("FAIL ro_wr c%0d got %b exp 110", c, {ROM_CE_N, ROM_WE_N, ROM_DQ_OE}); end
    end
    IS_WRITABLE = 1'b1; snes_wr_end = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      snes_wr_end = 1'b0;
      act = c <= 5;
      we  = c >= 2 && c <= 4;
      if (ROM_WE_N === 1'b0) we_cnt++;
      vec++; if ({ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_DQ_OE, ROM_BLE_N, ROM_BHE_N} !== {~act, 1'b1, ~we, act, ~act, 1'b1}) begin err++; $display("FAIL wr_strobes c%0d got %b exp %b", c, {ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_DQ_OE, ROM_BLE_N, ROM_BHE_N}, {~act, 1'b1, ~we, act, ~act, 1'b1}); end
      if (act) begin
        vec++; if (ROM_A !== 23'h700008 || ROM_DQ_OUT !== 16'h3C3C) begin err++; $display("FAIL wr_bus c%0d got a=%h dq=%h exp 700008 3c3c", c, ROM_A, ROM_DQ_OUT); end
      end
    end
    vec++; if (we_cnt !== 3) begin err++; $display("FAIL wr_we_len got %0d exp 3", we_cnt); end
    IS_WRITABLE = 1'b0;
  endtask

  task automatic test_back_to_back();
    ROM_ADDR = 24'h000010; ROM_HIT = 1'b1; ROM_DQ_IN = 16'h1234; snes_rd_start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      snes_rd_start = c == 2 || c == 3;
      ROM_ADDR = c == 2 ? 24'h000021 : 24'h000030;
      vec++; if (ROM_CE_N !== !((c <= 5) || (c >= 7 && c <= 11))) begin err++; $display("FAIL b2b_ce c%0d got %b exp %b", c, ROM_CE_N, !((c <= 5) || (c >= 7 && c <= 11))); end
      vec++; if (snes_rd_valid !== (c == 6 || c == 12)) begin err++; $display("FAIL b2b_valid c%0d got %b exp %b", c, snes_rd_valid, c == 6 || c == 12); end
      if (c == 6) begin
        vec++; if (snes_rddata !== 8'h34) begin err++; $display("FAIL b2b_data1 got %h exp 34", snes_rddata); end
        ROM_DQ_IN = 16'hBEEF;
      end
      if (c == 7) begin
        vec++; if (ROM_A !== 23'h18 || ROM_BLE_N !== 1'b0) begin err++; $display("FAIL b2b_latest got a=%h ble=%b exp 18 0", ROM_A, ROM_BLE_N); end
      end
      if (c == 12) begin
        vec++; if (snes_rddata !== 8'hEF) begin err++; $display("FAIL b2b_data2 got %h exp ef", snes_rddata); end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    ROM_ADDR = 24'h000444; ROM_HIT = 1'b1; IS_WRITABLE = 1'b1; SNES_DATA_IN = 8'h5E; snes_wr_end = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      snes_wr_end = 1'b0;
    end
    vec++; if (ROM_WE_N !== 1'b0 || ROM_CE_N !== 1'b0) begin err++; $display("FAIL rst_pre got we=%b ce=%b exp 0 0", ROM_WE_N, ROM_CE_N); end
    #1 RST = 1'b1;
    #1;
    vec++; if ({ROM_WE_N, ROM_CE_N, ROM_DQ_OE} !== 3'b110) begin err++; $display("FAIL rst_async got %b exp 110", {ROM_WE_N, ROM_CE_N, ROM_DQ_OE}); end
    @(negedge CLK);
    RST = 1'b0; IS_WRITABLE = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      vec++; if ({ROM_CE_N, ROM_WE_N, snes_rd_valid, mcu_rdy} !== 4'b1101) begin err++; $display("FAIL rst_after c%0d got %b exp 1101", c, {ROM_CE_N, ROM_WE_N, snes_rd_valid, mcu_rdy}); end
    end
  endtask

`ifdef ROM_PORT_MCU_EN
  task automatic test_mcu_priority();
    ROM_ADDR = 24'h000200; ROM_HIT = 1'b1; ROM_DQ_IN = 16'h5AC3; snes_rd_start = 1'b1;
    mcu_addr = 24'h000101; mcu_rrq = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge CLK);
      snes_rd_start = 1'b0; mcu_rrq = 1'b0;
      vec++; if (ROM_CE_N !== !((c <= 5) || (c >= 7 && c <= 11))) begin err++; $display("FAIL pri_ce c%0d got %b", c, ROM_CE_N); end
      vec++; if (mcu_rdy !== (c >= 13)) begin err++; $display("FAIL pri_rdy c%0d got %b exp %b", c, mcu_rdy, c >= 13); end
      vec++; if (snes_rd_valid !== (c == 6)) begin err++; $display("FAIL pri_valid c%0d got %b exp %b", c, snes_rd_valid, c == 6); end
      if (c == 3) begin
        vec++; if (ROM_A !== 23'h100) begin err++; $display("FAIL pri_snes_a got %h exp 100", ROM_A); end
      end
      if (c == 9) begin
        vec++; if (ROM_A !== 23'h80 || ROM_BHE_N !== 1'b0) begin err++; $display("FAIL pri_mcu_a got a=%h bhe=%b exp 80 0", ROM_A, ROM_BHE_N); end
      end
      if (c == 6) begin
        vec++; if (snes_rddata !== 8'hC3) begin err++; $display("FAIL pri_snes_d got %h exp c3", snes_rddata); end
      end
      if (c == 13) begin
        vec++; if (mcu_rddata !== 8'h5A) begin err++; $display("FAIL pri_mcu_d got %h exp 5a", mcu_rddata); end
      end
    end
  endtask

  task automatic test_mcu_worst_case();
    mcu_addr = 24'h000040; mcu_wrdata = 8'h77; mcu_wrq = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      mcu_wrq = 1'b0;
      snes_rd_start = c == 1; mcu_rrq = c == 1;
      ROM_ADDR = 24'h000003; ROM_HIT = 1'b1; ROM_DQ_IN = 16'h9911;
      vec++; if (ROM_WE_N !== !(c >= 2 && c <= 4)) begin err++; $display("FAIL wc_we c%0d got %b", c, ROM_WE_N); end
      vec++; if (ROM_CE_N !== !((c <= 5) || (c >= 7 && c <= 11))) begin err++; $display("FAIL wc_ce c%0d got %b", c, ROM_CE_N); end
      vec++; if (snes_rd_valid !== (c == 12)) begin err++; $display("FAIL wc_valid c%0d got %b exp %b", c, snes_rd_valid, c == 12); end
      vec++; if (mcu_rdy !== (c >= 7)) begin err++; $display("FAIL wc_rdy c%0d got %b exp %b", c, mcu_rdy, c >= 7); end
      if (c == 3) begin
        vec++; if (ROM_A !== 23'h20 || ROM_DQ_OUT !== 16'h7777 || ROM_DQ_OE !== 1'b1) begin err++; $display("FAIL wc_mcu_bus got a=%h dq=%h oe=%b", ROM_A, ROM_DQ_OUT, ROM_DQ_OE); end
      end
      if (c == 12) begin
        vec++; if (snes_rddata !== 8'h99) begin err++; $display("FAIL wc_data got %h exp 99", snes_rddata); end
      end
    end
  endtask
`else
  task automatic test_mcu_disabled();
    mcu_addr = 24'h000123; mcu_wrdata = 8'hAA; mcu_rrq = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      mcu_rrq = 1'b0; mcu_wrq = c == 2;
      vec++; if ({mcu_rdy, ROM_CE_N, ROM_WE_N, ROM_DQ_OE} !== 4'b1110) begin err++; $display("FAIL nomcu c%0d got %b exp 1110", c, {mcu_rdy, ROM_CE_N, ROM_WE_N, ROM_DQ_OE}); end
      vec++; if (mcu_rddata !== 8'h00) begin err++; $display("FAIL nomcu_d c%0d got %h exp 00", c, mcu_rddata); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_snes_read();
    test_qualify();
    test_back_to_back();
`ifdef ROM_PORT_MCU_EN
    test_mcu_priority();
    test_mcu_worst_case();
`else
    test_mcu_disabled();
`endif
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
